coeff_loader: RTL and testbench

- Upstream feeder for the coefficient FIFO.
- Accepts a valid/ready stream of 32-bit IEEE-754 coefficient words from the host/config path and issues FIFO write strobes, one word per cycle.
- Bounds each set to the FIFO depth, filters words that collide with the start-marker pattern, and appends the NaN start marker (0x7F900000) after the last coefficient so the FIFO raises its start flag.
- Reports set completion, word count and error flags to the control FSM.

---
 rtl/coeff_loader.sv | 129 ++++++++++++
 tb/tb_coeff_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_loader.sv
// Coefficient FIFO feeder: forwards host words to the FIFO, drops marker-pattern
// words, bounds each set to the FIFO depth and terminates it with the start marker.
module coeff_loader #(
    parameter int unsigned          RAM_WIDTH    = 32,
    parameter int unsigned          ADDR_LINES   = 5,
    parameter logic [RAM_WIDTH-1:0] START_MARKER = 32'h7F900000
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [RAM_WIDTH-1:0]  s_data_i,
    input  logic                  s_last_i,
    input  logic                  flush_i,
    input  logic                  fifo_full_i,
    output logic                  fifo_wr_en_o,
    output logic [RAM_WIDTH-1:0]  fifo_data_o,
    output logic [ADDR_LINES:0]   coeff_cnt_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  nan_err_o,
    output logic                  ovf_err_o
);

    localparam int unsigned          DEPTH     = 2 ** ADDR_LINES;
    localparam logic [ADDR_LINES:0]  DEPTH_CNT = (ADDR_LINES + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, MARK, DONE} state_e;

    state_e                 state_q, state_d;
    logic                   wr_en_q, wr_en_d;
    logic [RAM_WIDTH-1:0]   data_q, data_d;
    logic [ADDR_LINES:0]    cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   nan_err_q, nan_err_d;
    logic                   ovf_err_q, ovf_err_d;

    logic                   accept;
    logic                   is_marker;
    logic [ADDR_LINES:0]    cnt_inc;

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign s_ready_o = rstn_i && (state_q == IDLE || state_q == LOAD) &&
                       !fifo_full_i && (cnt_q < DEPTH_CNT);
    assign accept    = s_valid_i && s_ready_o;
    assign is_marker = (s_data_i == START_MARKER);
    assign cnt_inc   = cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        data_d    = data_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        nan_err_d = nan_err_q;
        ovf_err_d = ovf_err_q;

        unique case (state_q)
            IDLE, LOAD: begin
                if (state_q == IDLE && flush_i) begin
                    nan_err_d = 1'b0;
                    ovf_err_d = 1'b0;
                end
                if (accept) begin
                    state_d = LOAD;
                    if (is_marker) begin
                        nan_err_d = 1'b1;
                    end else begin
                        wr_en_d = 1'b1;
                        data_d  = s_data_i;
                        cnt_d   = cnt_inc;
                    end
                    // An explicit last wins over the depth limit, so a full set that
                    // ends exactly on DEPTH words is not flagged as an overflow.
                    if (s_last_i) begin
                        state_d = MARK;
                    end else if (!is_marker && cnt_inc == DEPTH_CNT) begin
                        state_d   = MARK;
                        ovf_err_d = 1'b1;
                    end
                end
            end
            MARK: begin
                wr_en_d = 1'b1;
                data_d  = START_MARKER;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (flush_i) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    nan_err_d = 1'b0;
                    ovf_err_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            data_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            nan_err_q <= 1'b0;
            ovf_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            nan_err_q <= nan_err_d;
            ovf_err_q <= ovf_err_d;
        end
    end

    assign fifo_wr_en_o = wr_en_q;
    assign fifo_data_o  = data_q;
    assign coeff_cnt_o  = cnt_q;
    assign done_o       = done_q;
    assign busy_o       = (state_q == LOAD) || (state_q == MARK);
    assign nan_err_o    = nan_err_q;
    assign ovf_err_o    = ovf_err_q;

endmodule

// File: tb/tb_coeff_loader.sv
// Testbench for coeff_loader: directed and random sets checked against a
// set-level model of which words reach the FIFO, in what order and when.
module tb_coeff_loader;

    localparam int          DEPTH  = 32;
    localparam logic [31:0] MARKER = 32'h7F900000;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        s_valid_i, s_ready_o, s_last_i, flush_i, fifo_full_i;
    logic [31:0] s_data_i;
    logic        fifo_wr_en_o, done_o, busy_o, nan_err_o, ovf_err_o;
    logic [31:0] fifo_data_o;
    logic [5:0]  coeff_cnt_o;

    coeff_loader #(.RAM_WIDTH(32), .ADDR_LINES(5), .START_MARKER(32'h7F900000)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .s_data_i(s_data_i), .s_last_i(s_last_i), .flush_i(flush_i),
        .fifo_full_i(fifo_full_i), .fifo_wr_en_o(fifo_wr_en_o), .fifo_data_o(fifo_data_o),
        .coeff_cnt_o(coeff_cnt_o), .done_o(done_o), .busy_o(busy_o),
        .nan_err_o(nan_err_o), .ovf_err_o(ovf_err_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] w_data[$];
    bit          w_last[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    time         got_t[$];
    int          done_cnt = 0;
    time         done_t   = 0;

    always @(negedge clk_i) begin
        if (fifo_wr_en_o === 1'b1) begin
            got_q.push_back(fifo_data_o);
            got_t.push_back($time);
        end
        if (done_o === 1'b1) begin
            done_cnt++;
            done_t = $time;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Set-level reference: which host words are consumed and what the FIFO must see.
    task automatic model_set(output int consumed, output int cnt, output bit nan, output bit ovf);
        exp_q.delete();
        consumed = 0; cnt = 0; nan = 0; ovf = 0;
        foreach (w_data[i]) begin
            consumed = i + 1;
            if (w_data[i] == MARKER) nan = 1;
            else begin exp_q.push_back(w_data[i]); cnt++; end
            if (w_last[i]) break;
            if (cnt == DEPTH) begin ovf = 1; break; end
        end
        exp_q.push_back(MARKER);
    endtask

    function automatic logic [31:0] rand_word(input bit allow_marker);
        logic [31:0] w;
        w = $urandom;
        while (w == MARKER) w = $urandom;
        if (allow_marker && $urandom_range(5) == 0) w = MARKER;
        return w;
    endfunction

    task automatic run_set(input string tag, input int stall_after, input int stall_len, input bit rnd);
        int  consumed, cnt, idx, guard, stall_left, k;
        bit  nan, ovf, acc, stalled;
        time acc_t[$];
        time last_t;
        int  base_done;
        model_set(consumed, cnt, nan, ovf);
        got_q.delete(); got_t.delete();
        base_done = done_cnt;
        idx = 0; guard = 0; stall_left = 0; last_t = 0;
        while (idx < consumed && guard < 1000) begin
            @(negedge clk_i);
            guard++;
            stalled     = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            fifo_full_i = stalled || (rnd && $urandom_range(3) == 0);
            s_valid_i   = rnd ? ($urandom_range(3) != 0) : 1'b1;
            s_data_i    = w_data[idx];
            s_last_i    = w_last[idx];
            #1;
            if (stalled) chk({tag, "_stall_ready"}, 32'(s_ready_o), 32'd0);
            acc = s_valid_i && s_ready_o;
            @(posedge clk_i);
            if (acc) begin
                if (w_data[idx] != MARKER) acc_t.push_back($time);
                last_t = $time;
                idx++;
                if (idx == stall_after) stall_left = stall_len;
            end
        end
        chk({tag, "_consumed"}, 32'(idx), 32'(consumed));
        @(negedge clk_i);
        s_valid_i = 1'b0; s_last_i = 1'b0; fifo_full_i = 1'b0;
        k = 0;
        while (done_cnt == base_done && k < 20) begin @(negedge clk_i); k++; end
        repeat (2) @(negedge clk_i);
        #1;
        chk({tag, "_nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_data%0d", tag, i), got_q[i], exp_q[i]);
        for (int i = 0; i < acc_t.size() && i < got_t.size(); i++)
            chk($sformatf("%s_lat%0d", tag, i), 32'(got_t[i]), 32'(acc_t[i] + 5));
        if (got_t.size() > 0) begin
            chk({tag, "_mark_t"}, 32'(got_t[got_t.size()-1]), 32'(last_t + 15));
            chk({tag, "_done_t"}, 32'(done_t), 32'(got_t[got_t.size()-1]));
        end
        chk({tag, "_ndone"}, 32'(done_cnt - base_done), 32'd1);
        chk({tag, "_cnt"}, 32'(coeff_cnt_o), 32'(cnt));
        chk({tag, "_nan"}, 32'(nan_err_o), 32'(nan));
        chk({tag, "_ovf"}, 32'(ovf_err_o), 32'(ovf));
        chk({tag, "_ready"}, 32'(s_ready_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    task automatic do_flush(input string tag);
        @(negedge clk_i) flush_i = 1'b1;
        @(negedge clk_i) flush_i = 1'b0;
        #1;
        chk({tag, "_cnt"}, 32'(coeff_cnt_o), 32'd0);
        chk({tag, "_nan"}, 32'(nan_err_o), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf_err_o), 32'd0);
        chk({tag, "_ready"}, 32'(s_ready_o), 32'd1);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int n, base_done;
        bit acc;
        rstn_i = 1'b0; s_valid_i = 1'b0; s_data_i = '0; s_last_i = 1'b0;
        flush_i = 1'b0; fifo_full_i = 1'b0;
        #1;
        chk("rst_wr_en", 32'(fifo_wr_en_o), 32'd0);
        chk("rst_data",  fifo_data_o, 32'd0);
        chk("rst_cnt",   32'(coeff_cnt_o), 32'd0);
        chk("rst_done",  32'(done_o), 32'd0);
        chk("rst_busy",  32'(busy_o), 32'd0);
        chk("rst_errs",  32'({nan_err_o, ovf_err_o}), 32'd0);
        chk("rst_ready", 32'(s_ready_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        #1 chk("idle_ready", 32'(s_ready_o), 32'd1);

        w_data = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        w_last = '{0, 0, 0, 1};
        run_set("basic", 0, 0, 0);
        do_flush("flush1");

        w_data = '{32'h3F800000, 32'h7F900000, 32'h40000000};
        w_last = '{0, 0, 1};
        run_set("nanword", 0, 0, 0);
        do_flush("flush2");

        w_data.delete(); w_last.delete();
        for (int i = 0; i < DEPTH + 5; i++) begin
            w_data.push_back(rand_word(0)); w_last.push_back(0);
        end
        run_set("ovf", 0, 0, 0);
        do_flush("flush3");

        w_data.delete(); w_last.delete();
        for (int i = 0; i < 5; i++) begin
            w_data.push_back(rand_word(0)); w_last.push_back(i == 4);
        end
        run_set("stall", 2, 3, 0);
        do_flush("flush4");

        w_data = '{32'h40A00000};
        w_last = '{1};
        run_set("single", 0, 0, 0);
        do_flush("flush5");

        for (int s = 0; s < 5; s++) begin
            n = $urandom_range(40, 1);
            w_data.delete(); w_last.delete();
            for (int i = 0; i < n; i++) begin
                w_data.push_back(rand_word(1));
                w_last.push_back(i == n - 1 || $urandom_range(9) == 0);
            end
            run_set($sformatf("rnd%0d", s), 0, 0, 1);
            do_flush($sformatf("rflush%0d", s));
        end

        // Reset while the third word's write strobe is in flight.
        got_q.delete(); got_t.delete();
        base_done = done_cnt;
        n = 0;
        for (int g = 0; g < 50 && n < 3; g++) begin
            @(negedge clk_i);
            s_valid_i = 1'b1; s_data_i = rand_word(0); s_last_i = 1'b0;
            #1 acc = s_ready_o;
            @(posedge clk_i);
            if (acc) n++;
        end
        chk("mrst_accepts", 32'(n), 32'd3);
        #1 rstn_i = 1'b0;
        #1;
        chk("mrst_wr_en", 32'(fifo_wr_en_o), 32'd0);
        chk("mrst_data",  fifo_data_o, 32'd0);
        chk("mrst_cnt",   32'(coeff_cnt_o), 32'd0);
        chk("mrst_busy",  32'(busy_o), 32'd0);
        s_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (5) @(negedge clk_i);
        #1;
        chk("mrst_nwr",  32'(got_q.size()), 32'd2);
        chk("mrst_done", 32'(done_cnt - base_done), 32'd0);
        chk("mrst_cnt2", 32'(coeff_cnt_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
